// File: rtl/result_diff_monitor_pkg.sv
// Shared defaults, FSM encoding and saturating-increment helper for the
// result_diff_monitor block.
package result_diff_monitor_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_NARROW  = 7;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_SAMPLES = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Increment v, holding at 2^w-1 (w up to 31).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= lim) return lim[31:0];
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/result_diff_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over inc.
module result_diff_monitor_sat_counter
  import result_diff_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (inc) begin
      value <= CNT_W'(sat_inc(32'(value), CNT_W));
    end
  end

endmodule

// File: rtl/result_diff_monitor.sv
// Windowed checker comparing the wide and narrow a+1 results, with a
// two-stage compare pipeline feeding saturating match/mismatch/error counters.
module result_diff_monitor
  import result_diff_monitor_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NARROW  = DEF_NARROW,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int SAMPLES = DEF_SAMPLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  result_a,
  input  logic [NARROW-1:0] result_b,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  err_a_cnt,
  output logic              first_mis_vld,
  output logic [WIDTH-1:0]  first_mis_a
);

  localparam int ACC_W = $clog2(SAMPLES + 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc_cnt;
  logic             accept, last_accept, run_clear;

  logic              vld_p1, vld_p2;
  logic [WIDTH-1:0]  a_p1, result_a_p1, a_p2;
  logic [NARROW-1:0] result_b_p1;
  logic              match_p1, err_p1, match_p2, err_p2;

  assign accept      = in_valid && in_ready;
  assign last_accept = accept && (acc_cnt == ACC_W'(SAMPLES - 1));
  assign run_clear   = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // DRAIN leaves once stage 1 is empty: stage 2 retires on that same edge,
  // so the counters are final in the DONE cycle and DRAIN lasts two cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (last_accept) state_nxt = DRAIN;
      DRAIN: if (!vld_p1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        in_ready = (acc_cnt < ACC_W'(SAMPLES));
        busy     = 1'b1;
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || run_clear) acc_cnt <= '0;
    else if (accept)      acc_cnt <= acc_cnt + ACC_W'(1);
  end

  // Stage 1: capture the accepted sample
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1        <= a;
      result_a_p1 <= result_a;
      result_b_p1 <= result_b;
    end
  end

  assign match_p1 = (result_a_p1 == {{(WIDTH - NARROW){1'b0}}, result_b_p1});
  assign err_p1   = (result_a_p1 != (a_p1 + WIDTH'(1)));

  // Stage 2: register compare outcome, then retire into the counters
  always_ff @(posedge clk) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      a_p2     <= a_p1;
      match_p2 <= match_p1;
      err_p2   <= err_p1;
    end
  end

  result_diff_monitor_sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (run_clear),
    .inc   (vld_p2 && match_p2),
    .value (match_cnt)
  );

  result_diff_monitor_sat_counter #(.CNT_W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (run_clear),
    .inc   (vld_p2 && !match_p2),
    .value (mismatch_cnt)
  );

  result_diff_monitor_sat_counter #(.CNT_W(CNT_W)) u_err_a_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (run_clear),
    .inc   (vld_p2 && err_p2),
    .value (err_a_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst || run_clear) begin
      first_mis_vld <= 1'b0;
      first_mis_a   <= '0;
    end else if (vld_p2 && !match_p2 && !first_mis_vld) begin
      first_mis_vld <= 1'b1;
      first_mis_a   <= a_p2;
    end
  end

endmodule

// File: tb/tb_result_diff_monitor.sv
// Directed bench: several monitor instances with different windows share one
// sample bus; each run starts exactly one of them.
module tb_result_diff_monitor;

  localparam int NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [NI-1:0]     start = '0;
  logic              in_valid = 1'b0;
  logic [7:0]        a = '0, result_a = '0;
  logic [6:0]        result_b = '0;
  logic [NI-1:0]     rdy, bsy, dn, fv;
  logic [NI-1:0][15:0] mc, mm, ec;
  logic [NI-1:0][7:0]  fa;
  logic [3:0]        mc20, mm20, ec20;

  assign mc[4] = {12'd0, mc20};
  assign mm[4] = {12'd0, mm20};
  assign ec[4] = {12'd0, ec20};

  result_diff_monitor #(.WIDTH(8), .NARROW(7), .CNT_W(16), .SAMPLES(256)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .a(a), .result_a(result_a), .result_b(result_b), .busy(bsy[0]), .done(dn[0]),
    .match_cnt(mc[0]), .mismatch_cnt(mm[0]), .err_a_cnt(ec[0]),
    .first_mis_vld(fv[0]), .first_mis_a(fa[0]));

  result_diff_monitor #(.WIDTH(8), .NARROW(7), .CNT_W(16), .SAMPLES(4)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .a(a), .result_a(result_a), .result_b(result_b), .busy(bsy[1]), .done(dn[1]),
    .match_cnt(mc[1]), .mismatch_cnt(mm[1]), .err_a_cnt(ec[1]),
    .first_mis_vld(fv[1]), .first_mis_a(fa[1]));

  result_diff_monitor #(.WIDTH(8), .NARROW(7), .CNT_W(16), .SAMPLES(16)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .a(a), .result_a(result_a), .result_b(result_b), .busy(bsy[2]), .done(dn[2]),
    .match_cnt(mc[2]), .mismatch_cnt(mm[2]), .err_a_cnt(ec[2]),
    .first_mis_vld(fv[2]), .first_mis_a(fa[2]));

  result_diff_monitor #(.WIDTH(8), .NARROW(7), .CNT_W(16), .SAMPLES(8)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .in_valid(in_valid), .in_ready(rdy[3]),
    .a(a), .result_a(result_a), .result_b(result_b), .busy(bsy[3]), .done(dn[3]),
    .match_cnt(mc[3]), .mismatch_cnt(mm[3]), .err_a_cnt(ec[3]),
    .first_mis_vld(fv[3]), .first_mis_a(fa[3]));

  result_diff_monitor #(.WIDTH(8), .NARROW(7), .CNT_W(4), .SAMPLES(20)) u4 (
    .clk(clk), .rst(rst), .start(start[4]), .in_valid(in_valid), .in_ready(rdy[4]),
    .a(a), .result_a(result_a), .result_b(result_b), .busy(bsy[4]), .done(dn[4]),
    .match_cnt(mc20), .mismatch_cnt(mm20), .err_a_cnt(ec20),
    .first_mis_vld(fv[4]), .first_mis_a(fa[4]));

  typedef struct {
    string name;
    int inst, n, a0, bad;
    int exp_acc, exp_m, exp_mm, exp_e, exp_fv, exp_fa;
  } run_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // The wide result is corrupted to a+2 only for a == bad.
  task automatic set_sample(input int v, input int bad);
    a        = 8'(v);
    result_a = 8'(v + ((v == bad) ? 2 : 1));
    result_b = 7'(v + 1);
  endtask

  task automatic check_zero(input string tag, input int k);
    chk({tag, ".match"}, 32'(mc[k]), 0);
    chk({tag, ".mismatch"}, 32'(mm[k]), 0);
    chk({tag, ".err_a"}, 32'(ec[k]), 0);
    chk({tag, ".first_vld"}, 32'(fv[k]), 0);
    chk({tag, ".first_a"}, 32'(fa[k]), 0);
    chk({tag, ".busy"}, 32'(bsy[k]), 0);
    chk({tag, ".in_ready"}, 32'(rdy[k]), 0);
    chk({tag, ".done"}, 32'(dn[k]), 0);
  endtask

  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic run_vec(input run_t r);
    int idx = 0, cyc = 0, last_acc = -100, nacc = 0;
    bit seen = 1'b0, acc;
    start[r.inst] = 1'b1;
    @(negedge clk);
    start[r.inst] = 1'b0;
    while (!seen && cyc < 2000) begin
      if (idx < r.n) begin
        in_valid = 1'b1;
        set_sample(r.a0 + idx, r.bad);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && rdy[r.inst];
      @(posedge clk);
      cyc++;
      if (acc) begin
        nacc++;
        last_acc = cyc;
      end
      if (in_valid) idx++;
      @(negedge clk);
      if (dn[r.inst]) seen = 1'b1;
    end
    in_valid = 1'b0;
    chk({r.name, ".done_seen"}, 32'(seen), 1);
    chk({r.name, ".accepts"}, 32'(nacc), 32'(r.exp_acc));
    chk({r.name, ".done_latency"}, 32'(cyc - last_acc), 2);
    chk({r.name, ".busy_at_done"}, 32'(bsy[r.inst]), 0);
    chk({r.name, ".ready_at_done"}, 32'(rdy[r.inst]), 0);
    chk({r.name, ".match"}, 32'(mc[r.inst]), 32'(r.exp_m));
    chk({r.name, ".mismatch"}, 32'(mm[r.inst]), 32'(r.exp_mm));
    chk({r.name, ".err_a"}, 32'(ec[r.inst]), 32'(r.exp_e));
    chk({r.name, ".first_vld"}, 32'(fv[r.inst]), 32'(r.exp_fv));
    chk({r.name, ".first_a"}, 32'(fa[r.inst]), 32'(r.exp_fa));
    @(negedge clk);
    chk({r.name, ".done_one_cycle"}, 32'(dn[r.inst]), 0);
    chk({r.name, ".match_held"}, 32'(mc[r.inst]), 32'(r.exp_m));
  endtask

  initial begin
    run_t vecs[6];
    run_t fresh;
    int seen_done;
    int fl_v[5] = '{1, 0, 1, 0, 1};
    int fl_a[5] = '{126, 0, 127, 0, 0};

    //         name       inst  n   a0  bad  acc  m    mm   e  fv  fa
    vecs[0] = '{"sweep",   0, 256,   0, -1, 256, 128, 128, 0, 1, 127};
    vecs[1] = '{"window4", 1,   5,  10, -1,   4,   4,   0, 0, 0,   0};
    vecs[2] = '{"wrap4",   1,   4, 253, -1,   4,   2,   2, 0, 1, 253};
    vecs[3] = '{"corrupt", 2,  16,   0,  5,  16,  15,   1, 1, 1,   5};
    vecs[4] = '{"edge8",   3,   8, 120, -1,   8,   7,   1, 0, 1, 127};
    vecs[5] = '{"sat20",   4,  20,   0, -1,  20,  15,   0, 0, 0,   0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_zero("reset0", 0);
    check_zero("reset4", 4);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Flow control on the 8-sample instance: gaps in in_valid, stray start in RUN.
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = fl_v[i][0];
      set_sample(fl_a[i], -1);
      start[3] = (i == 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start[3] = 1'b0;
    repeat (2) @(negedge clk);
    chk("flow.match", 32'(mc[3]), 2);
    chk("flow.mismatch", 32'(mm[3]), 1);
    chk("flow.err_a", 32'(ec[3]), 0);
    chk("flow.first_vld", 32'(fv[3]), 1);
    chk("flow.first_a", 32'(fa[3]), 127);
    chk("flow.busy", 32'(bsy[3]), 1);
    chk("flow.in_ready", 32'(rdy[3]), 1);

    // Reset in the middle of that run discards it.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("midreset", 3);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (dn[3]) seen_done++;
    end
    chk("midreset.no_done", 32'(seen_done), 0);
    chk("midreset.idle_busy", 32'(bsy[3]), 0);

    fresh = '{"fresh8", 3, 8, 0, -1, 8, 8, 0, 0, 0, 0};
    run_vec(fresh);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
